// File: rtl/regfile_write_master.sv
// Single write-port master for the 32x32 register file: arbitrates the pipeline
// writeback against a FIFO of long-latency results, with anti-starvation hold.
module regfile_write_master #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wb_en,
    input  logic [4:0]                wb_reg,
    input  logic [31:0]               wb_data,
    output logic                      wb_hold,
    input  logic                      lr_valid,
    output logic                      lr_ready,
    input  logic [4:0]                lr_reg,
    input  logic [31:0]               lr_data,
    input  logic [4:0]                query1,
    input  logic [4:0]                query2,
    output logic                      busy1,
    output logic                      busy2,
    output logic [4:0]                WriteReg,
    output logic [31:0]               WriteData,
    output logic                      RegWrite,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_reg_q  [DEPTH];
    logic [4:0]    fifo_reg_d  [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;
    logic          err_q, err_d;

    logic fifo_empty;
    logic wb_req;
    logic wb_win;
    logic violation;
    logic pop;
    logic push;

    // Handshake: a long-latency result transfers on an edge where lr_valid && lr_ready;
    // lr_ready depends on occupancy only, so a same-cycle pop never frees a slot early.
    assign fifo_empty = (count_q == '0);
    assign lr_ready   = (count_q < DEPTH_C);
    assign wb_hold    = (starve_q == LIMIT_C);
    assign wb_req     = wb_en && (wb_reg != 5'd0);
    assign wb_win     = wb_req && !wb_hold;
    assign violation  = wb_req && wb_hold;
    assign pop        = !wb_win && !fifo_empty;
    assign push       = lr_valid && lr_ready && (lr_reg != 5'd0);

    always_comb begin
        fifo_reg_d   = fifo_reg_q;
        fifo_data_d  = fifo_data_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        starve_d     = '0;
        err_d        = err_q | violation;

        if (wb_win) begin
            reg_write_d  = 1'b1;
            write_reg_d  = wb_reg;
            write_data_d = wb_data;
            // wb can only win below the limit, so the increment saturates by construction
            if (!fifo_empty) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (pop) begin
            reg_write_d  = 1'b1;
            write_reg_d  = fifo_reg_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end

        if (push) begin
            fifo_reg_d[wr_ptr_q]  = lr_reg;
            fifo_data_d[wr_ptr_q] = lr_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                if (fifo_reg_q[rd_ptr_q + AW'(k)] == query1) busy1 = 1'b1;
                if (fifo_reg_q[rd_ptr_q + AW'(k)] == query2) busy2 = 1'b1;
            end
        end
        if (reg_write_q && (write_reg_q == query1)) busy1 = 1'b1;
        if (reg_write_q && (write_reg_q == query2)) busy2 = 1'b1;
        if (query1 == 5'd0) busy1 = 1'b0;
        if (query2 == 5'd0) busy2 = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            fifo_reg_q   <= fifo_reg_d;
            fifo_data_q  <= fifo_data_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            err_q        <= err_d;
        end
    end

    assign RegWrite   = reg_write_q;
    assign WriteReg   = write_reg_q;
    assign WriteData  = write_data_q;
    assign fifo_count = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_regfile_write_master.sv
// Bench for regfile_write_master: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_write_master;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int CW           = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          wb_en;
    logic [4:0]    wb_reg;
    logic [31:0]   wb_data;
    logic          wb_hold;
    logic          lr_valid;
    logic          lr_ready;
    logic [4:0]    lr_reg;
    logic [31:0]   lr_data;
    logic [4:0]    query1;
    logic [4:0]    query2;
    logic          busy1;
    logic          busy2;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic          RegWrite;
    logic [CW-1:0] fifo_count;
    logic          err;

    always #5 clock = ~clock;

    regfile_write_master #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wb_en(wb_en),
        .wb_reg(wb_reg),
        .wb_data(wb_data),
        .wb_hold(wb_hold),
        .lr_valid(lr_valid),
        .lr_ready(lr_ready),
        .lr_reg(lr_reg),
        .lr_data(lr_data),
        .query1(query1),
        .query2(query2),
        .busy1(busy1),
        .busy2(busy2),
        .WriteReg(WriteReg),
        .WriteData(WriteData),
        .RegWrite(RegWrite),
        .fifo_count(fifo_count),
        .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending long-latency writes as a queue, plus the port contents.
    logic [36:0] m_q[$];
    logic        m_rw     = 1'b0;
    logic [4:0]  m_wr     = '0;
    logic [31:0] m_wd     = '0;
    int          m_starve = 0;
    logic        m_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_busy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i][36:32] == q) return 1'b1;
        return m_rw && (m_wr == q);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_rw     = 1'b0;
            m_wr     = '0;
            m_wd     = '0;
            m_starve = 0;
            m_err    = 1'b0;
        end else begin
            logic        hold;
            logic        ready;
            logic        wb_valid;
            logic [36:0] e;
            hold     = (m_starve == STARVE_LIMIT);
            ready    = (m_q.size() < DEPTH);
            wb_valid = wb_en && (wb_reg != 5'd0);
            if (wb_valid && hold) m_err = 1'b1;
            if (wb_valid && !hold) begin
                m_rw = 1'b1;
                m_wr = wb_reg;
                m_wd = wb_data;
                if (m_q.size() > 0)
                    m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
                else
                    m_starve = 0;
            end else if (m_q.size() > 0) begin
                e        = m_q.pop_front();
                m_rw     = 1'b1;
                m_wr     = e[36:32];
                m_wd     = e[31:0];
                m_starve = 0;
            end else begin
                m_rw     = 1'b0;
                m_starve = 0;
            end
            if (lr_valid && ready && (lr_reg != 5'd0)) m_q.push_back({lr_reg, lr_data});
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            check("RegWrite", 32'(RegWrite), 32'(m_rw));
            check("WriteReg", 32'(WriteReg), 32'(m_wr));
            check("WriteData", WriteData, m_wd);
            check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            check("lr_ready", 32'(lr_ready), 32'(m_q.size() < DEPTH));
            check("wb_hold", 32'(wb_hold), 32'(m_starve == STARVE_LIMIT));
            check("err", 32'(err), 32'(m_err));
            check("busy1", 32'(busy1), 32'(model_busy(query1)));
            check("busy2", 32'(busy2), 32'(model_busy(query2)));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wb_en    = 1'b0;
        wb_reg   = '0;
        wb_data  = '0;
        lr_valid = 1'b0;
        lr_reg   = '0;
        lr_data  = '0;
    endtask

    initial begin
        idle();
        query1 = '0;
        query2 = '0;
        reset  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_RegWrite", 32'(RegWrite), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_lr_ready", 32'(lr_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Basic writeback path
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        check("wb_RegWrite", 32'(RegWrite), 32'd1);
        check("wb_WriteReg", 32'(WriteReg), 32'd5);
        check("wb_WriteData", WriteData, 32'hDEADBEEF);
        idle();
        tick();
        check("wb_idle_RegWrite", 32'(RegWrite), 32'd0);
        check("wb_idle_WriteReg", 32'(WriteReg), 32'd5);

        // Fill FIFO while writeback keeps winning
        wb_en = 1'b1; wb_reg = 5'd9; lr_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wb_data = 32'h9000_0000 + k;
            lr_reg  = 5'(k);
            lr_data = 32'h100 + k;
            tick();
        end
        check("fill_count", 32'(fifo_count), 32'd4);
        check("fill_ready", 32'(lr_ready), 32'd0);
        check("fill_hold_early", 32'(wb_hold), 32'd0);
        lr_reg = 5'd5; lr_data = 32'h105;
        tick();
        check("fill_hold", 32'(wb_hold), 32'd1);
        check("fill_WriteReg9", 32'(WriteReg), 32'd9);
        check("fill_full_count", 32'(fifo_count), 32'd4);
        idle();
        tick();
        check("drain_WriteReg1", 32'(WriteReg), 32'd1);
        check("drain_WriteData1", WriteData, 32'h101);
        check("drain_hold_drop", 32'(wb_hold), 32'd0);
        check("drain_count3", 32'(fifo_count), 32'd3);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("drain_WriteReg", 32'(WriteReg), 32'(k));
            check("drain_WriteData", WriteData, 32'h100 + k);
        end
        check("drain_empty", 32'(fifo_count), 32'd0);
        tick();
        check("drain_idle", 32'(RegWrite), 32'd0);

        // Zero register handling
        lr_valid = 1'b1; lr_reg = 5'd0; lr_data = 32'h55;
        check("zero_ready", 32'(lr_ready), 32'd1);
        tick();
        check("zero_count", 32'(fifo_count), 32'd0);
        wb_en = 1'b1; wb_reg = 5'd9; lr_reg = 5'd7; lr_data = 32'h77;
        tick();
        check("zero_q7_count", 32'(fifo_count), 32'd1);
        idle();
        wb_en = 1'b1; wb_reg = 5'd0;
        tick();
        check("zero_pop_reg", 32'(WriteReg), 32'd7);
        check("zero_pop_data", WriteData, 32'h77);
        check("zero_pop_count", 32'(fifo_count), 32'd0);
        idle();
        tick();

        // Busy flags
        wb_en = 1'b1; wb_reg = 5'd9; lr_valid = 1'b1; lr_reg = 5'd12; lr_data = 32'hC;
        tick();
        lr_valid = 1'b0; query1 = 5'd12; query2 = 5'd0;
        #1;
        check("busy_q1", 32'(busy1), 32'd1);
        check("busy_q2", 32'(busy2), 32'd0);
        idle();
        tick();
        check("busy_port_reg", 32'(WriteReg), 32'd12);
        check("busy_port_q1", 32'(busy1), 32'd1);
        tick();
        check("busy_done_rw", 32'(RegWrite), 32'd0);
        check("busy_done_q1", 32'(busy1), 32'd0);

        // Protocol violation during hold
        wb_en = 1'b1; wb_reg = 5'd9; lr_valid = 1'b1; lr_reg = 5'd20; lr_data = 32'h14;
        tick();
        lr_valid = 1'b0;
        repeat (4) tick();
        check("viol_hold", 32'(wb_hold), 32'd1);
        wb_reg = 5'd3; wb_data = 32'h33;
        tick();
        check("viol_WriteReg", 32'(WriteReg), 32'd20);
        check("viol_WriteData", WriteData, 32'h14);
        check("viol_err", 32'(err), 32'd1);
        idle();
        repeat (3) tick();
        check("viol_err_sticky", 32'(err), 32'd1);
        check("viol_no_reg3", 32'(WriteReg), 32'd20);

        // Asynchronous reset with entries queued
        wb_en = 1'b1; wb_reg = 5'd9; lr_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            lr_reg  = 5'(20 + k);
            lr_data = 32'h200 + k;
            tick();
        end
        idle();
        query1 = 5'd22;
        #1;
        check("mid_busy_before", 32'(busy1), 32'd1);
        check("mid_count_before", 32'(fifo_count), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_RegWrite", 32'(RegWrite), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ready", 32'(lr_ready), 32'd1);
        check("mid_rst_busy1", 32'(busy1), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (wb_hold) wb_en = ($urandom_range(0, 49) == 0);
            else         wb_en = ($urandom_range(0, 99) < 60);
            wb_reg   = 5'($urandom_range(0, 7));
            wb_data  = $urandom();
            lr_valid = ($urandom_range(0, 1) == 1);
            lr_reg   = 5'($urandom_range(0, 7));
            lr_data  = $urandom();
            query1   = 5'($urandom_range(0, 7));
            query2   = 5'($urandom_range(0, 7));
            tick();
        end
        idle();
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
